// File: rtl/inv_cipher_core_if.sv
// Handshake and data bundle between the inverse-cipher core and its host / key schedule.
interface inv_cipher_core_if;
  logic         start;
  logic [127:0] ct;
  logic [127:0] rk;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;
  logic [127:0] pt;

  modport master (output start, ct, rk, input round_idx, busy, done, pt);
  modport slave  (input start, ct, rk, output round_idx, busy, done, pt);
endinterface

// File: rtl/inv_cipher_core.sv
// AES-128 inverse cipher, one round per clock over a single 128-bit state register.
// Round keys come from an external schedule addressed by round_idx.
//
// state | meaning
// IDLE  | waiting for start; round_idx = 10, key addition of ct happens on the start edge
// ROUND | inverse rounds 9..1; round_idx = counter
// FINAL | last round without InvMixColumns; pt captured and done pulsed on exit

module add_round_key (
  input  logic [127:0] data_i,
  input  logic [127:0] key_i,
  output logic [127:0] data_o
);
  assign data_o = data_i ^ key_i;
endmodule

module inv_sub_bytes (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero naturally.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    logic [7:0] p;
    logic [7:0] r;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    p = b;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  always_comb begin
    data_o = '0;
    for (int i = 0; i < 16; i++)
      data_o[127-8*i -: 8] = inv_sbox(data_i[127-8*i -: 8]);
  end
endmodule

module inv_cipher_core (
  input  logic                     clk,
  input  logic                     rst,
  inv_cipher_core_if.slave         bus
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_e;

  fsm_e         state_q, state_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] pt_q, pt_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   ridx_q, ridx_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [127:0] isr, isb, ark_in, ark, imc;

  // Byte index is row + 4*column; row r is rotated right by r bytes.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = s[127-8*(r+4*c) -: 8];
        m9[r] = xt(xt(xt(a[r]))) ^ a[r];
        mb[r] = xt(xt(xt(a[r]))) ^ xt(a[r]) ^ a[r];
        md[r] = xt(xt(xt(a[r]))) ^ xt(xt(a[r])) ^ a[r];
        me[r] = xt(xt(xt(a[r]))) ^ xt(xt(a[r])) ^ xt(a[r]);
      end
      o[127-8*(4*c)   -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[127-8*(1+4*c) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[127-8*(2+4*c) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[127-8*(3+4*c) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return o;
  endfunction

  assign isr = inv_shift_rows(blk_q);

  inv_sub_bytes u_isb (.data_i(isr), .data_o(isb));

  // One key adder serves both the initial ct whitening and every later round.
  assign ark_in = (state_q == IDLE) ? bus.ct : isb;

  add_round_key u_ark (.data_i(ark_in), .key_i(bus.rk), .data_o(ark));

  assign imc = inv_mix_columns(ark);

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    pt_d    = pt_q;
    cnt_d   = cnt_q;
    ridx_d  = ridx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        ridx_d = 4'd10;
        if (bus.start) begin
          blk_d   = ark;
          cnt_d   = 4'd9;
          ridx_d  = 4'd9;
          busy_d  = 1'b1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        blk_d = imc;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          ridx_d  = 4'd0;
          state_d = FINAL;
        end else begin
          ridx_d = cnt_q - 4'd1;
        end
      end
      FINAL: begin
        pt_d    = ark;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
        ridx_d  = 4'd10;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        ridx_d  = 4'd10;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
      pt_q    <= '0;
      cnt_q   <= 4'd0;
      ridx_q  <= 4'd10;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      pt_q    <= pt_d;
      cnt_q   <= cnt_d;
      ridx_q  <= ridx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.round_idx = ridx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pt        = pt_q;
endmodule

// File: tb/tb_inv_cipher_core.sv
// Bench for inv_cipher_core: known-answer table, multi-cycle corner sequences and
// random round trips against a forward AES-128 model.
module tb_inv_cipher_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inv_cipher_core_if ifc ();
  inv_cipher_core dut (.clk(clk), .rst(rst), .bus(ifc));

  logic [127:0] ks [0:10];
  logic [7:0]   sbox_t [0:255];
  int vectors = 0;
  int miscompares = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  always_comb begin
    ifc.rk = '0;
    if (ifc.round_idx <= 4'd10) ifc.rk = ks[ifc.round_idx];
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key, output logic [127:0] rks [0:10]);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic encrypt(input logic [127:0] key, input logic [127:0] pt, output logic [127:0] ct);
    logic [127:0] rks [0:10];
    logic [7:0] s [16];
    logic [7:0] t [16];
    expand(key, rks);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rks[0][127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r+4*c] = sbox_t[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) begin
        if (rnd != 10) begin
          s[4*c]   = gmul(t[4*c],2) ^ gmul(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],2) ^ gmul(t[4*c+2],3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],2) ^ gmul(t[4*c+3],3);
          s[4*c+3] = gmul(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],2);
        end else begin
          for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*c];
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= rks[rnd][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
  endtask

  // Starts a block, optionally corrupts ct right after the start edge, waits for done.
  task automatic run_block(input logic [127:0] key, input logic [127:0] ct_v,
                           input logic [127:0] exp_pt, input bit glitch, input string nm);
    int n;
    expand(key, ks);
    @(negedge clk);
    ifc.ct = ct_v;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    if (glitch) ifc.ct = '1;
    n = 1;
    while (!ifc.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 128'(n), 128'd11);
    chk({nm, "_pt"}, ifc.pt, exp_pt);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  initial begin
    vec_t tbl [3];
    logic [127:0] rks [0:10];
    logic [127:0] key, ptv, ctv, ct_b, pt_b;
    int busy_cnt, dones, done_at1, done_at2;

    tbl[0] = '{C1_KEY, C1_CT, C1_PT};
    tbl[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
               128'h3243f6a8885a308d313198a2e0370734};
    tbl[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};

    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.ct = '0;
    build_sbox();
    expand(C1_KEY, rks);
    chk("model_rk10", rks[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    ks = rks;

    @(negedge clk);
    chk("rst_busy", 128'(ifc.busy), 128'd0);
    chk("rst_done", 128'(ifc.done), 128'd0);
    chk("rst_pt", ifc.pt, 128'd0);
    chk("rst_ridx", 128'(ifc.round_idx), 128'd10);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++)
      run_block(tbl[i].key, tbl[i].ct, tbl[i].pt, 1'b0, $sformatf("kat%0d", i));

    // round_idx trace and busy width
    expand(C1_KEY, ks);
    @(negedge clk);
    ifc.ct = C1_CT;
    ifc.start = 1'b1;
    busy_cnt = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      ifc.start = 1'b0;
      busy_cnt += int'(ifc.busy);
      if (n <= 11)
        chk($sformatf("trace_ridx%0d", n), 128'(ifc.round_idx),
            (n <= 9) ? 128'(10 - n) : (n == 10) ? 128'd0 : 128'd10);
      if (n == 11) chk("trace_done", 128'(ifc.done), 128'd1);
      if (n == 11) chk("trace_pt", ifc.pt, C1_PT);
      if (n == 12) chk("trace_done_width", 128'(ifc.done), 128'd0);
    end
    chk("trace_busy_cycles", 128'(busy_cnt), 128'd10);

    // back-to-back with ignored starts while busy
    pt_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    encrypt(C1_KEY, pt_b, ct_b);
    @(negedge clk);
    ifc.ct = C1_CT;
    ifc.start = 1'b1;
    dones = 0;
    done_at1 = 0;
    done_at2 = 0;
    for (int n = 1; n <= 26; n++) begin
      @(negedge clk);
      ifc.start = 1'b0;
      if (ifc.done) begin
        dones++;
        if (dones == 1) done_at1 = n; else done_at2 = n;
      end
      if (n == 11) chk("b2b_pt1", ifc.pt, C1_PT);
      if (n == 22) chk("b2b_pt2", ifc.pt, pt_b);
      if (n == 3 || n == 15) ifc.start = 1'b1;
      if (n == 11) begin
        ifc.ct = ct_b;
        ifc.start = 1'b1;
      end
    end
    chk("b2b_done_count", 128'(dones), 128'd2);
    chk("b2b_first_done", 128'(done_at1), 128'd11);
    chk("b2b_spacing", 128'(done_at2 - done_at1), 128'd11);

    // reset in the middle of a block
    @(negedge clk);
    ifc.ct = C1_CT;
    ifc.start = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      ifc.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("abort_busy", 128'(ifc.busy), 128'd0);
    chk("abort_done", 128'(ifc.done), 128'd0);
    chk("abort_pt", ifc.pt, 128'd0);
    chk("abort_ridx", 128'(ifc.round_idx), 128'd10);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      dones += int'(ifc.done);
    end
    chk("abort_no_done", 128'(dones), 128'd0);
    run_block(C1_KEY, C1_CT, C1_PT, 1'b0, "after_abort");

    run_block(C1_KEY, C1_CT, C1_PT, 1'b1, "ct_change");

    for (int i = 0; i < 1000; i++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      ptv = {$urandom(), $urandom(), $urandom(), $urandom()};
      encrypt(key, ptv, ctv);
      run_block(key, ctv, ptv, 1'b0, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
